// File: rtl/rx_deserializer.sv
// Serial-to-parallel receive deserializer: configurable width and shift direction,
// double-buffered output word with ready/read handshake and sticky overrun flag.
module rx_deserializer #(
    parameter int unsigned NUM_BITS  = 8,
    parameter bit          SHIFT_MSB = 1'b0
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          clear,
    input  logic                          shift_enable,
    input  logic                          serial_in,
    input  logic                          data_read,
    output logic [NUM_BITS-1:0]           parallel_out,
    output logic                          word_ready,
    output logic                          overrun,
    output logic [$clog2(NUM_BITS+1)-1:0] bit_count
);

    localparam int unsigned     CntW    = $clog2(NUM_BITS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_BITS - 1);

    logic [NUM_BITS-1:0] sr_q, sr_d;
    logic [NUM_BITS-1:0] sr_shift;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_BITS-1:0] word_q, word_d;
    logic                ready_q, ready_d;
    logic                overrun_q, overrun_d;
    logic                last_bit;
    logic                complete;

    always_comb begin
        if (SHIFT_MSB) begin
            sr_shift = {sr_q[NUM_BITS-2:0], serial_in};
        end else begin
            sr_shift = {serial_in, sr_q[NUM_BITS-1:1]};
        end
    end

    assign last_bit = (cnt_q == LastCnt);
    // clear discards the strobed bit, so it can never complete a word
    assign complete = shift_enable && !clear && last_bit;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_enable) begin
            sr_d  = sr_shift;
            cnt_d = last_bit ? '0 : cnt_q + CntW'(1);
        end
    end

    always_comb begin
        word_d    = word_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        if (complete) begin
            word_d  = sr_shift;
            ready_d = 1'b1;
            // an unread word is lost unless it is being read on this very edge
            if (ready_q && !data_read) begin
                overrun_d = 1'b1;
            end
        end else if (data_read) begin
            ready_d = 1'b0;
        end
        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    assign parallel_out = word_q;
    assign word_ready   = ready_q;
    assign overrun      = overrun_q;
    assign bit_count    = cnt_q;

endmodule

// File: tb/tb_rx_deserializer.sv
// Bench for rx_deserializer: three instances (8/LSB-first, 8/MSB-first, 12/LSB-first) share
// one stimulus stream; a positional reference model feeds a per-cycle scoreboard.
module tb_rx_deserializer;

    logic clk;
    logic n_rst;
    logic clear;
    logic shift_enable;
    logic serial_in;
    logic data_read;

    logic [7:0]  po0, po1;
    logic [11:0] po2;
    logic [2:0]  rdy, ovr;
    logic [3:0]  bc0, bc1, bc2;

    rx_deserializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) u_lsb8 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .data_read(data_read), .parallel_out(po0),
        .word_ready(rdy[0]), .overrun(ovr[0]), .bit_count(bc0)
    );

    rx_deserializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) u_msb8 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .data_read(data_read), .parallel_out(po1),
        .word_ready(rdy[1]), .overrun(ovr[1]), .bit_count(bc1)
    );

    rx_deserializer #(.NUM_BITS(12), .SHIFT_MSB(1'b0)) u_lsb12 (
        .clk(clk), .n_rst(n_rst), .clear(clear), .shift_enable(shift_enable),
        .serial_in(serial_in), .data_read(data_read), .parallel_out(po2),
        .word_ready(rdy[2]), .overrun(ovr[2]), .bit_count(bc2)
    );

    logic [2:0][31:0] act_word;
    logic [2:0][3:0]  act_cnt;
    assign act_word[0] = {24'b0, po0};
    assign act_word[1] = {24'b0, po1};
    assign act_word[2] = {20'b0, po2};
    assign act_cnt[0]  = bc0;
    assign act_cnt[1]  = bc1;
    assign act_cnt[2]  = bc2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][31:0] word;
        logic [2:0]       ready;
        logic [2:0]       ovr;
        logic [2:0][3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a word is simply the N received bits placed by arrival position.
    localparam int W[3]    = '{8, 8, 12};
    localparam bit MSBF[3] = '{1'b0, 1'b1, 1'b0};

    int          m_cnt[3];
    logic [31:0] m_acc[3];
    logic [31:0] m_held[3];
    logic        m_ready[3];
    logic        m_ovr[3];

    task automatic model_step(input logic r, input logic c, input logic se, input logic si,
                              input logic rd);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (!r) begin
                m_cnt[k]   = 0;
                m_acc[k]   = '0;
                m_held[k]  = '0;
                m_ready[k] = 1'b0;
                m_ovr[k]   = 1'b0;
            end else if (c) begin
                m_cnt[k] = 0;
                m_acc[k] = '0;
                m_ovr[k] = 1'b0;
                if (rd) m_ready[k] = 1'b0;
            end else begin
                bit done;
                done = 1'b0;
                if (se) begin
                    int pos;
                    pos = MSBF[k] ? (W[k] - 1 - m_cnt[k]) : m_cnt[k];
                    if (si) m_acc[k] = m_acc[k] | (32'd1 << pos);
                    m_cnt[k]++;
                    if (m_cnt[k] == W[k]) begin
                        done = 1'b1;
                        if (m_ready[k] && !rd) m_ovr[k] = 1'b1;
                        m_held[k]  = m_acc[k];
                        m_ready[k] = 1'b1;
                        m_cnt[k]   = 0;
                        m_acc[k]   = '0;
                    end
                end
                if (!done && rd) m_ready[k] = 1'b0;
            end
            e.word[k]  = m_held[k];
            e.ready[k] = m_ready[k];
            e.ovr[k]   = m_ovr[k];
            e.cnt[k]   = 4'(m_cnt[k]);
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic c, input logic se, input logic si,
                        input logic rd);
        @(negedge clk);
        n_rst        = r;
        clear        = c;
        shift_enable = se;
        serial_in    = si;
        data_read    = rd;
        model_step(r, c, se, si, rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_word();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] v, input int n, input bit msbf, input int gap,
                             input bit rd_last);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = msbf ? v[n-1-i] : v[i];
            step(1'b1, 1'b0, 1'b1, b, rd_last && (i == n - 1));
            if (i != n - 1) idle(gap);
        end
    endtask

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, expv);
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare all outputs of all instances.
    exp_t got_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                got_e = exp_q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    check("parallel_out", k, act_word[k], got_e.word[k]);
                    check("word_ready", k, 32'(rdy[k]), 32'(got_e.ready[k]));
                    check("overrun", k, 32'(ovr[k]), 32'(got_e.ovr[k]));
                    check("bit_count", k, 32'(act_cnt[k]), 32'(got_e.cnt[k]));
                end
            end
        end
    end

    initial begin
        n_rst        = 1'b0;
        clear        = 1'b0;
        shift_enable = 1'b0;
        serial_in    = 1'b0;
        data_read    = 1'b0;

        // reset, then 0xA5 LSB-first
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send_word(32'hA5, 8, 1'b0, 0, 1'b0);
        idle(2);
        read_word();

        // 0xC3 MSB-first, back to back and gapped
        send_word(32'hC3, 8, 1'b1, 0, 1'b0);
        read_word();
        send_word(32'hC3, 8, 1'b1, 3, 1'b0);
        read_word();

        // hold unread, then read on the final strobe of the next word
        send_word(32'h3C, 8, 1'b0, 0, 1'b0);
        idle(4);
        send_word(32'h96, 8, 1'b0, 0, 1'b1);
        read_word();

        // overrun, then clear keeps the held word
        send_word(32'h11, 8, 1'b0, 0, 1'b0);
        send_word(32'h22, 8, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        read_word();

        // clear together with a strobe mid-word
        send_word(32'h15, 5, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_word(32'hFF, 8, 1'b0, 0, 1'b0);
        read_word();

        // reset mid-word, then a 12-bit word
        send_word(32'h5A, 7, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_word(32'hABC, 12, 1'b0, 0, 1'b0);
        idle(1);
        read_word();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic r, c, se, si, rd;
            r  = ($urandom_range(0, 299) != 0);
            c  = ($urandom_range(0, 39) == 0);
            se = ($urandom_range(0, 2) != 0);
            si = 1'($urandom);
            rd = ($urandom_range(0, 5) == 0);
            step(r, c, se, si, rd);
        end
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
